// File: rtl/play_session_ctrl.sv
// Play-mode session controller: steps through a song note by note on a tick timebase,
// grades one hit per note, and keeps score/combo plus a per-user best-score/best-combo table.
module play_session_ctrl #(
    parameter int NUM_USERS  = 8,
    parameter int USER_W     = 3,
    parameter int IDX_W      = 8,
    parameter int DUR_W      = 8,
    parameter int SCORE_W    = 20,
    parameter int COMBO_STEP = 10,
    parameter int MULT_MAX   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [USER_W-1:0]  user,
    input  logic [1:0]         mode,
    input  logic [IDX_W-1:0]   track_len,
    input  logic               tick,
    input  logic [DUR_W-1:0]   note_dur,
    input  logic               hit_valid,
    input  logic [1:0]         hit_grade,
    output logic [IDX_W-1:0]   note_idx,
    output logic               note_active,
    output logic               busy,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] combo,
    output logic [SCORE_W-1:0] max_combo,
    output logic               done,
    output logic               new_best,
    output logic [SCORE_W-1:0] best_score
);

    typedef enum logic [1:0] {IDLE, PLAY, RESULT} state_t;

    localparam logic [DUR_W:0]     DUR_ONE   = 1;
    localparam logic [IDX_W-1:0]   IDX_ONE   = 1;
    localparam logic [SCORE_W-1:0] SCORE_ONE = 1;
    localparam logic [SCORE_W-1:0] STEP_C    = SCORE_W'(COMBO_STEP);
    localparam logic [SCORE_W-1:0] MULT_C    = SCORE_W'(MULT_MAX);

    state_t state, state_next;

    logic [USER_W-1:0]  user_q;
    logic [1:0]         mode_q;
    logic [IDX_W-1:0]   len_q;
    logic [DUR_W:0]     timer;
    logic               judged;
    logic [SCORE_W-1:0] tbl_score [NUM_USERS];
    logic [SCORE_W-1:0] tbl_combo [NUM_USERS];

    logic [DUR_W:0]     dur_raw, dur_scaled;
    logic               in_play, judge, note_end, last_note;
    logic [SCORE_W-1:0] steps, mult, gain, cur_best;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next, combo_next, max_next;

    always_comb begin
        case (mode_q)
            2'b10:   dur_raw = {note_dur, 1'b0};
            2'b11:   dur_raw = {2'b00, note_dur[DUR_W-1:1]};
            default: dur_raw = {1'b0, note_dur};
        endcase
        dur_scaled = (dur_raw == '0) ? DUR_ONE : dur_raw;
    end

    // Abort suppresses both judgement and note end on the same cycle.
    assign in_play   = (state == PLAY);
    assign judge     = in_play && hit_valid && !judged && !abort;
    assign note_end  = in_play && tick && !abort && ((timer + DUR_ONE) == dur_scaled);
    assign last_note = (note_idx == (len_q - IDX_ONE));

    assign steps     = combo / STEP_C;
    assign mult      = (steps >= (MULT_C - SCORE_ONE)) ? MULT_C : (steps + SCORE_ONE);
    assign gain      = SCORE_W'(hit_grade) * mult;
    assign score_sum = {1'b0, score} + {1'b0, gain};
    assign cur_best  = tbl_score[user_q];

    always_comb begin
        score_next = score;
        combo_next = combo;
        if (judge) begin
            if (hit_grade != 2'd0) begin
                score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                combo_next = (combo == '1) ? combo : (combo + SCORE_ONE);
            end else begin
                combo_next = '0;
            end
        end else if (note_end && !judged) begin
            combo_next = '0;
        end
        max_next = (combo_next > max_combo) ? combo_next : max_combo;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (track_len == '0) ? RESULT : PLAY;
            PLAY: begin
                if (abort)                      state_next = IDLE;
                else if (note_end && last_note) state_next = RESULT;
            end
            RESULT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            user_q    <= '0;
            mode_q    <= '0;
            len_q     <= '0;
            timer     <= '0;
            judged    <= 1'b0;
            note_idx  <= '0;
            score     <= '0;
            combo     <= '0;
            max_combo <= '0;
            for (int i = 0; i < NUM_USERS; i++) begin
                tbl_score[i] <= '0;
                tbl_combo[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: if (start) begin
                    user_q    <= user;
                    mode_q    <= mode;
                    len_q     <= track_len;
                    timer     <= '0;
                    judged    <= 1'b0;
                    note_idx  <= '0;
                    score     <= '0;
                    combo     <= '0;
                    max_combo <= '0;
                end
                PLAY: begin
                    score     <= score_next;
                    combo     <= combo_next;
                    max_combo <= max_next;
                    if (note_end) begin
                        timer  <= '0;
                        judged <= 1'b0;
                        if (!last_note) note_idx <= note_idx + IDX_ONE;
                    end else begin
                        if (tick && !abort) timer <= timer + DUR_ONE;
                        if (judge) judged <= 1'b1;
                    end
                end
                RESULT: begin
                    if (score > cur_best)               tbl_score[user_q] <= score;
                    if (max_combo > tbl_combo[user_q]) tbl_combo[user_q] <= max_combo;
                end
                default: ;
            endcase
        end
    end

    assign note_active = in_play;
    assign busy        = (state != IDLE);
    assign done        = (state == RESULT);
    assign new_best    = (state == RESULT) && (score > cur_best);
    assign best_score  = tbl_score[user];

endmodule

// File: tb/tb_play_session_ctrl.sv
// Self-checking bench for play_session_ctrl: fixed vector table, directed corner sequences,
// and randomized sessions scored by a note-level reference model.
module tb_play_session_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, start, abort, tick, hit_valid;
    logic [2:0]  user;
    logic [1:0]  mode, hit_grade;
    logic [7:0]  track_len, note_dur;
    logic [7:0]  note_idx;
    logic        note_active, busy, done, new_best;
    logic [19:0] score, combo, max_combo, best_score;

    int errors = 0;
    int checks = 0;

    // Reference state: session totals and the best-score table, advanced one whole note at a time.
    int m_tbl [8];
    int m_score, m_combo, m_max;
    int song [16];
    int det_grade [16];

    typedef struct {
        int md;
        int dur;
        int grade;
        int hit_tick;
        int exp_ticks;
        int exp_score;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    play_session_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .user(user), .mode(mode),
        .track_len(track_len), .tick(tick), .note_dur(note_dur), .hit_valid(hit_valid),
        .hit_grade(hit_grade), .note_idx(note_idx), .note_active(note_active), .busy(busy),
        .score(score), .combo(combo), .max_combo(max_combo), .done(done), .new_best(new_best),
        .best_score(best_score)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic hv, input logic [1:0] g, input logic ab);
        tick      = t;
        hit_valid = hv;
        hit_grade = g;
        abort     = ab;
        @(posedge clk);
        #1;
        tick      = 1'b0;
        hit_valid = 1'b0;
        hit_grade = 2'd0;
        abort     = 1'b0;
        start     = 1'b0;
    endtask

    function automatic int scaled(input int d, input int m);
        int s;
        if (m == 2)      s = d * 2;
        else if (m == 3) s = d / 2;
        else             s = d;
        return (s == 0) ? 1 : s;
    endfunction

    function automatic void modelNote(input int g);
        int mul;
        if (g == 0) begin
            m_combo = 0;
        end else begin
            mul = 1 + m_combo / 10;
            if (mul > 4) mul = 4;
            m_score += g * mul;
            m_combo++;
            if (m_combo > m_max) m_max = m_combo;
        end
    endfunction

    task automatic runSession(input int u, input int md, input int len, input bit rnd);
        int sd, k_hit, g, g2;
        bit has_hit, dbl, hv;
        user = 3'(u); mode = 2'(md); track_len = 8'(len); start = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        m_score = 0; m_combo = 0; m_max = 0;
        checkOutput("start_busy", 32'(busy), 1);
        checkOutput("start_score", 32'(score), 0);
        if (len == 0) begin
            checkOutput("empty_done", 32'(done), 1);
            checkOutput("empty_new_best", 32'(new_best), 0);
        end else begin
            for (int n = 0; n < len; n++) begin
                checkOutput("note_idx", 32'(note_idx), n);
                checkOutput("note_active", 32'(note_active), 1);
                note_dur = 8'(song[n]);
                sd = scaled(song[n], md);
                if (rnd) begin
                    has_hit = ($urandom_range(0, 3) != 0);
                    k_hit   = $urandom_range(0, sd - 1);
                    g       = $urandom_range(0, 3);
                    dbl     = ($urandom_range(0, 2) == 0);
                end else begin
                    has_hit = 1'b1; k_hit = 0; g = det_grade[n]; dbl = 1'b0;
                end
                for (int k = 0; k < sd; k++) begin
                    if (rnd && $urandom_range(0, 1) == 1) begin
                        start = ($urandom_range(0, 3) == 0);
                        user = 3'($urandom_range(0, 7));
                        track_len = 8'($urandom_range(0, 9));
                        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
                    end
                    hv = has_hit && ((k == k_hit) || (dbl && k == sd - 1));
                    g2 = (k == k_hit) ? g : $urandom_range(0, 3);
                    applyStimulus(1'b1, hv, 2'(g2), 1'b0);
                end
                modelNote(has_hit ? g : 0);
                if (n < len - 1) begin
                    checkOutput("note_score", 32'(score), m_score);
                    checkOutput("note_combo", 32'(combo), m_combo);
                end
            end
            checkOutput("result_done", 32'(done), 1);
            checkOutput("result_new_best", 32'(new_best), (m_score > m_tbl[u]) ? 1 : 0);
        end
        checkOutput("result_score", 32'(score), m_score);
        checkOutput("result_combo", 32'(combo), m_combo);
        checkOutput("result_max_combo", 32'(max_combo), m_max);
        if (m_score > m_tbl[u]) m_tbl[u] = m_score;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("after_done", 32'(done), 0);
        checkOutput("after_busy", 32'(busy), 0);
        user = 3'(u);
        #1;
        checkOutput("after_best_score", 32'(best_score), m_tbl[u]);
    endtask

    initial begin
        int ticks;
        vecs[0] = '{md: 0, dur: 4, grade: 3, hit_tick: 0, exp_ticks: 4, exp_score: 3};
        vecs[1] = '{md: 1, dur: 4, grade: 2, hit_tick: 3, exp_ticks: 4, exp_score: 2};
        vecs[2] = '{md: 0, dur: 3, grade: 0, hit_tick: 0, exp_ticks: 3, exp_score: 0};
        vecs[3] = '{md: 0, dur: 2, grade: 3, hit_tick: 5, exp_ticks: 2, exp_score: 0};
        vecs[4] = '{md: 2, dur: 4, grade: 1, hit_tick: 7, exp_ticks: 8, exp_score: 1};
        vecs[5] = '{md: 3, dur: 1, grade: 3, hit_tick: 0, exp_ticks: 1, exp_score: 3};
        vecs[6] = '{md: 2, dur: 0, grade: 2, hit_tick: 0, exp_ticks: 1, exp_score: 2};
        vecs[7] = '{md: 3, dur: 5, grade: 3, hit_tick: 1, exp_ticks: 2, exp_score: 3};
        vecs[8] = '{md: 3, dur: 9, grade: 1, hit_tick: 3, exp_ticks: 4, exp_score: 1};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; tick = 1'b0; hit_valid = 1'b0;
        hit_grade = 2'd0; user = 3'd0; mode = 2'd0; track_len = 8'd0; note_dur = 8'd0;
        for (int i = 0; i < 8; i++) m_tbl[i] = 0;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b1;
        checkOutput("reset_busy", 32'(busy), 0);
        checkOutput("reset_score", 32'(score), 0);
        checkOutput("reset_note_idx", 32'(note_idx), 0);
        checkOutput("reset_done", 32'(done), 0);
        checkOutput("reset_best", 32'(best_score), 0);

        // Three perfect notes of four ticks each.
        for (int n = 0; n < 3; n++) begin song[n] = 4; det_grade[n] = 3; end
        runSession(2, 0, 3, 1'b0);
        checkOutput("tp1_score", 32'(score), 9);
        checkOutput("tp1_combo", 32'(combo), 3);
        checkOutput("tp1_best", 32'(best_score), 9);

        // Multiplier steps up once the pre-hit combo reaches ten.
        for (int n = 0; n < 12; n++) begin song[n] = 1; det_grade[n] = 3; end
        runSession(4, 0, 12, 1'b0);
        checkOutput("mult_score", 32'(score), 42);

        // Lower replay leaves the best at nine.
        song[0] = 2; song[1] = 2; det_grade[0] = 3; det_grade[1] = 2;
        runSession(2, 0, 2, 1'b0);
        checkOutput("replay_score", 32'(score), 5);
        checkOutput("replay_best", 32'(best_score), 9);

        // Abort on a note-end cycle that also carries a hit.
        user = 3'd2; mode = 2'd0; track_len = 8'd4; note_dur = 8'd3; start = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        checkOutput("abort_note_idx", 32'(note_idx), 1);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b1);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_done", 32'(done), 0);
        checkOutput("abort_score", 32'(score), 3);
        checkOutput("abort_combo", 32'(combo), 1);
        checkOutput("abort_max_combo", 32'(max_combo), 1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("abort_done_later", 32'(done), 0);
        checkOutput("abort_best", 32'(best_score), 9);

        runSession(5, 1, 0, 1'b0);

        // Single-note sessions with ticks every cycle, counted until done.
        for (int v = 0; v < 9; v++) begin
            user = 3'd6; mode = 2'(vecs[v].md); track_len = 8'd1; start = 1'b1;
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
            note_dur = 8'(vecs[v].dur);
            ticks = 0;
            while (!done && ticks < 40) begin
                applyStimulus(1'b1, ticks == vecs[v].hit_tick, 2'(vecs[v].grade), 1'b0);
                ticks++;
            end
            checkOutput("vec_ticks", ticks, vecs[v].exp_ticks);
            checkOutput("vec_score", 32'(score), vecs[v].exp_score);
            checkOutput("vec_combo", 32'(combo), (vecs[v].exp_score > 0) ? 1 : 0);
            if (vecs[v].exp_score > m_tbl[6]) m_tbl[6] = vecs[v].exp_score;
            if (!done) applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
            applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        end
        user = 3'd6;
        #1;
        checkOutput("vec_best", 32'(best_score), m_tbl[6]);

        for (int s = 0; s < 20; s++) begin
            int len;
            len = $urandom_range(1, 6);
            for (int n = 0; n < len; n++) song[n] = $urandom_range(0, 4);
            runSession($urandom_range(0, 7), $urandom_range(0, 3), len, 1'b1);
        end

        // Reset in the middle of a song wipes session and table.
        user = 3'd3; mode = 2'd0; track_len = 8'd4; note_dur = 8'd3; start = 1'b1;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0);
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_note_active", 32'(note_active), 0);
        checkOutput("rst_score", 32'(score), 0);
        checkOutput("rst_combo", 32'(combo), 0);
        checkOutput("rst_max_combo", 32'(max_combo), 0);
        checkOutput("rst_note_idx", 32'(note_idx), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_new_best", 32'(new_best), 0);
        for (int u = 0; u < 8; u++) begin
            user = 3'(u);
            #1;
            checkOutput("rst_best_score", 32'(best_score), 0);
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
